// File: rtl/mm_port_sequencer_if.sv
// Bundle of the two requester ports and the memory port of the main-memory sequencer.
// The master side drives requests and memory read data; the slave side is the sequencer.
interface mm_port_sequencer_if #(
  parameter int LINE_W = 66,
  parameter int ADDR_W = 8
);
  logic              req_CPU;
  logic              we_CPU;
  logic [ADDR_W-1:0] addr_CPU;
  logic [LINE_W-1:0] wdata_CPU;
  logic              req_EXT;
  logic              we_EXT;
  logic [ADDR_W-1:0] addr_EXT;
  logic [LINE_W-1:0] wdata_EXT;
  logic [LINE_W-1:0] mem_rdata;

  logic              gnt_CPU;
  logic              gnt_EXT;
  logic              done_CPU;
  logic              done_EXT;
  logic [LINE_W-1:0] rdata;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              busy;

  modport master (
    output req_CPU, we_CPU, addr_CPU, wdata_CPU,
    output req_EXT, we_EXT, addr_EXT, wdata_EXT,
    output mem_rdata,
    input  gnt_CPU, gnt_EXT, done_CPU, done_EXT, rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  req_CPU, we_CPU, addr_CPU, wdata_CPU,
    input  req_EXT, we_EXT, addr_EXT, wdata_EXT,
    input  mem_rdata,
    output gnt_CPU, gnt_EXT, done_CPU, done_EXT, rdata,
    output mem_re, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mm_port_sequencer.sv
// Round-robin sequencer that turns CPU / external-agent line requests into single
// memory transactions, waits out the memory latency and returns a done pulse.
module mm_port_sequencer #(
  parameter int LINE_W  = 66,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  mm_port_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_EXT  = 1'b1;
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t            state_q;
  state_t            state_d;
  logic              owner_q;
  logic              last_served_q;
  logic [3:0]        lat_cnt_q;

  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [LINE_W-1:0] wdata_p0;
  logic [LINE_W-1:0] rdata_p1;

  logic              req_any;
  logic              win_ext;
  logic              accept;
  logic              capture;

  // Arbitration: a lone requester wins; on a tie the side not served last wins.
  always_comb begin
    req_any = bus.req_CPU | bus.req_EXT;
    win_ext = bus.req_EXT & (~bus.req_CPU | (last_served_q == OWN_CPU));
    accept  = (state_q == IDLE) & req_any;
    capture = (state_q == WAIT) & (lat_cnt_q == 4'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A read always spends MEM_LAT cycles in WAIT, so the capture edge lands
  // exactly MEM_LAT cycles after the mem_re cycle for every legal latency.
  always_comb begin
    state_d      = state_q;
    bus.busy     = (state_q != IDLE);
    bus.gnt_CPU  = (state_q != IDLE) && (owner_q == OWN_CPU);
    bus.gnt_EXT  = (state_q != IDLE) && (owner_q == OWN_EXT);
    bus.done_CPU = 1'b0;
    bus.done_EXT = 1'b0;
    bus.mem_re   = 1'b0;
    bus.mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) state_d = ISSUE;
      end
      ISSUE: begin
        bus.mem_we = we_p0;
        bus.mem_re = ~we_p0;
        state_d    = we_p0 ? DONE : WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == 4'd0) state_d = DONE;
      end
      DONE: begin
        bus.done_CPU = (owner_q == OWN_CPU);
        bus.done_EXT = (owner_q == OWN_EXT);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: transaction latched from the winner at acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q       <= OWN_CPU;
      last_served_q <= OWN_EXT;
      lat_cnt_q     <= 4'd0;
      we_p0         <= 1'b0;
      addr_p0       <= '0;
      wdata_p0      <= '0;
    end else begin
      if (accept) begin
        owner_q  <= win_ext;
        we_p0    <= win_ext ? bus.we_EXT    : bus.we_CPU;
        addr_p0  <= win_ext ? bus.addr_EXT  : bus.addr_CPU;
        wdata_p0 <= win_ext ? bus.wdata_EXT : bus.wdata_CPU;
      end
      if (state_q == ISSUE) begin
        lat_cnt_q <= LAT_INIT;
      end else if (state_q == WAIT) begin
        lat_cnt_q <= lat_cnt_q - 4'd1;
      end
      if (state_q == DONE) begin
        last_served_q <= owner_q;
      end
    end
  end

  // Stage p1: read line captured from memory; writes leave it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_p1 <= '0;
    end else if (capture) begin
      rdata_p1 <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr  = addr_p0;
  assign bus.mem_wdata = wdata_p0;
  assign bus.rdata     = rdata_p1;

endmodule
